// File: rtl/mem_responder_if.sv
// Handshake bundle between the core (master) and mem_responder (slave):
// fetch port, data port, beat index and busy status.
interface mem_responder_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [15:0] d_rdata;
  logic [1:0]  beat_idx;
  logic        busy;

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata, beat_idx, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata, beat_idx, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Shared 16-bit word array behind fetch/data grant-valid ports, fixed LATENCY, data priority.
// Define MEMRESP_BURST_EN to return reads as 4-beat aligned 8-byte bursts.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_isData;
  logic                  r_wr;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic                  r_iValid;
  logic                  r_dValid;
  logic                  r_busy;
  logic [15:0]           r_iRdata;
  logic [15:0]           r_dRdata;
  logic [15:0]           r_mem [DEPTH];

  logic                  w_dGnt;
  logic                  w_iGnt;
  logic                  w_enterResp;
  logic                  w_lastBeat;
  logic                  w_memWe;
  logic                  w_curData;
  logic                  w_curWr;
  logic [DEPTH_LOG2-1:0] w_curAddr;
  logic [DEPTH_LOG2-1:0] w_rdAddr;
  logic [15:0]           w_curWdata;
  logic [15:0]           w_rspData;
  logic                  w_unused;

  assign w_dGnt = rst_n & (r_state == IDLE) & bus.d_req;
  assign w_iGnt = rst_n & (r_state == IDLE) & bus.i_req & ~bus.d_req;

  // In IDLE the response fields come straight from the request being granted (LATENCY=1 path).
  assign w_curData  = (r_state == IDLE) ? w_dGnt : r_isData;
  assign w_curWr    = (r_state == IDLE) ? (w_dGnt & bus.d_wr) : r_wr;
  assign w_curWdata = (r_state == IDLE) ? bus.d_wdata : r_wdata;
  assign w_curAddr  = (r_state != IDLE) ? r_addr :
                      (w_dGnt ? bus.d_addr[DEPTH_LOG2:1] : bus.i_addr[DEPTH_LOG2:1]);

  assign w_enterResp = ((r_state == IDLE) & (w_dGnt | w_iGnt) & (LATENCY == 1)) |
                       ((r_state == WAIT) & (r_cnt == 4'd1));
  assign w_rspData   = w_curWr ? w_curWdata : r_mem[w_rdAddr];
  assign w_memWe     = (r_state == RESP) & r_isData & r_wr;
  assign w_unused    = ^{bus.i_addr, bus.d_addr};

`ifdef MEMRESP_BURST_EN
  logic [1:0] r_beat;
  logic [1:0] w_rdBeat;

  assign w_rdBeat     = (r_state == RESP) ? r_beat + 2'd1 : 2'd0;
  assign w_rdAddr     = {w_curAddr[DEPTH_LOG2-1:2], w_rdBeat};
  assign w_lastBeat   = r_wr | (r_beat == 2'd3);
  assign bus.beat_idx = r_beat;
`else
  assign w_rdAddr     = w_curAddr;
  assign w_lastBeat   = 1'b1;
  assign bus.beat_idx = 2'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_isData <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_iValid <= 1'b0;
      r_dValid <= 1'b0;
      r_busy   <= 1'b0;
      r_iRdata <= '0;
      r_dRdata <= '0;
`ifdef MEMRESP_BURST_EN
      r_beat   <= 2'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dGnt | w_iGnt) begin
            r_isData <= w_dGnt;
            r_wr     <= w_curWr;
            r_addr   <= w_curAddr;
            r_wdata  <= bus.d_wdata;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_LOAD;
            r_state  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP: begin
          if (w_lastBeat) begin
            r_state  <= IDLE;
            r_iValid <= 1'b0;
            r_dValid <= 1'b0;
            r_busy   <= 1'b0;
`ifdef MEMRESP_BURST_EN
            r_beat   <= 2'd0;
          end else begin
            r_beat <= r_beat + 2'd1;
            if (r_isData) r_dRdata <= w_rspData;
            else          r_iRdata <= w_rspData;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_enterResp) begin
        if (w_curData) begin
          r_dValid <= 1'b1;
          r_dRdata <= w_rspData;
        end else begin
          r_iValid <= 1'b1;
          r_iRdata <= w_rspData;
        end
      end
    end
  end

  // Array is not reset; a write commits only on the edge that ends its RESP cycle.
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[r_addr] <= r_wdata;
  end

  assign bus.i_gnt   = w_iGnt;
  assign bus.d_gnt   = w_dGnt;
  assign bus.i_valid = r_iValid;
  assign bus.d_valid = r_dValid;
  assign bus.i_rdata = r_iRdata;
  assign bus.d_rdata = r_dRdata;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int DEPTH_LOG2 = 10;
  localparam int LAT        = 4;
`ifdef MEMRESP_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [1:0]  idx;
  } beat_t;

  logic        clk;
  logic        rst_n;
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mdl [2**DEPTH_LOG2];
  beat_t       dLog[$];
  beat_t       iLog[$];

  mem_responder_if bus();

  mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every response beat with the cycle it was seen in
  always @(negedge clk) begin
    if (bus.d_valid) dLog.push_back('{cyc, bus.d_rdata, bus.beat_idx});
    if (bus.i_valid) iLog.push_back('{cyc, bus.i_rdata, bus.beat_idx});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wordOf(input int byteAddr);
    return (byteAddr % (2 ** (DEPTH_LOG2 + 1))) / 2;
  endfunction

  function automatic int beatsFor(input bit wr);
    return (BURST != 0 && !wr) ? 4 : 1;
  endfunction

  function automatic logic [15:0] readBeat(input int addr, input int b);
    if (BURST != 0) return mdl[wordOf((addr / 8) * 8 + 2 * b)];
    return mdl[wordOf(addr)];
  endfunction

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit isD, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, output int g);
    g = -1;
    if (isD) begin
      bus.d_req   = 1'b1;
      bus.d_wr    = wr;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end else begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end
    for (int k = 0; k < 40 && g < 0; k++) begin
      @(negedge clk);
      if (isD ? bus.d_gnt : bus.i_gnt) g = cyc;
      @(posedge clk);
      #1;
    end
    if (isD) begin
      bus.d_req = 1'b0;
      bus.d_wr  = 1'b0;
    end else begin
      bus.i_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_wr = 1'b1;
    bus.i_addr = 16'h0; bus.d_addr = 16'h0; bus.d_wdata = 16'hFFFF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    checks++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b00)
      $display("[TB] FAIL reset_gnt: got %b expected 00", {bus.d_gnt, bus.i_gnt});
    checks++;
    if ({bus.d_valid, bus.i_valid, bus.busy, bus.beat_idx} !== 5'b0)
      $display("[TB] FAIL reset_status: got %b expected 00000",
               {bus.d_valid, bus.i_valid, bus.busy, bus.beat_idx});
    checks++;
    if (bus.d_rdata !== 16'h0) $display("[TB] FAIL reset_drdata: got %h expected 0000", bus.d_rdata);
    checks++;
    if (bus.i_rdata !== 16'h0) $display("[TB] FAIL reset_irdata: got %h expected 0000", bus.i_rdata);
    errors += ({bus.d_gnt, bus.i_gnt} !== 2'b00) + ({bus.d_valid, bus.i_valid, bus.busy, bus.beat_idx} !== 5'b0)
            + (bus.d_rdata !== 16'h0) + (bus.i_rdata !== 16'h0);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_prefill();
    logic [15:0] v;
    int g, start;
    for (int w = 0; w < 64; w++) begin
      v = 16'($urandom);
      dLog.delete(); iLog.delete();
      start = cyc;
      issue(1'b1, 1'b1, 16'(w * 2), v, g);
      waitUntil(g + LAT + 1);
      checks++;
      if (g !== start || dLog.size() !== 1 || iLog.size() !== 0 ||
          dLog[0].cyc !== g + LAT || dLog[0].data !== v) begin
        errors++;
        $display("[TB] FAIL prefill_w%0d: got gnt=%0d beats=%0d data=%h expected gnt=%0d beats=1 data=%h",
                 w, g, dLog.size(), (dLog.size() > 0) ? dLog[0].data : 16'h0, start, v);
      end
      mdl[w] = v;
    end
  endtask

  task automatic test_write_fetch();
    int dg, ig;
    dLog.delete(); iLog.delete();
    issue(1'b1, 1'b1, 16'h0010, 16'hBEEF, dg);
    mdl[wordOf(16'h0010)] = 16'hBEEF;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, ig);
    waitUntil(ig + LAT + beatsFor(1'b0));
    checks++;
    if (ig !== dg + LAT + 1) begin
      errors++;
      $display("[TB] FAIL wf_igrant: got cycle %0d expected %0d", ig, dg + LAT + 1);
    end
    checks++;
    if (dLog.size() !== 1 || dLog[0].cyc !== dg + LAT || dLog[0].data !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL wf_dack: got beats=%0d expected 1 beat of BEEF at cycle %0d", dLog.size(), dg + LAT);
    end
    checks++;
    if (iLog.size() !== beatsFor(1'b0) || iLog[0].cyc !== ig + LAT || iLog[0].data !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL wf_fetch: got beats=%0d data=%h expected %0d beats first=BEEF at cycle %0d",
               iLog.size(), (iLog.size() > 0) ? iLog[0].data : 16'h0, beatsFor(1'b0), ig + LAT);
    end
  endtask

  task automatic test_simultaneous();
    int dg, ig, nb;
    nb = beatsFor(1'b0);
    dLog.delete(); iLog.delete();
    bus.i_req = 1'b1; bus.i_addr = 16'h0000;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0010;
    @(negedge clk);
    dg = cyc;
    checks++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL sim_priority: got d_gnt,i_gnt=%b expected 10", {bus.d_gnt, bus.i_gnt});
    end
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    issue(1'b0, 1'b0, 16'h0000, 16'h0, ig);
    waitUntil(ig + LAT + nb);
    checks++;
    if (ig !== dg + LAT + 1) begin
      errors++;
      $display("[TB] FAIL sim_igrant: got cycle %0d expected %0d", ig, dg + LAT + 1);
    end
    checks++;
    if (dLog.size() !== nb || dLog[0].cyc !== dg + LAT || dLog[0].data !== readBeat(16'h0010, 0)) begin
      errors++;
      $display("[TB] FAIL sim_dread: got beats=%0d expected %0d first=%h", dLog.size(), nb, readBeat(16'h0010, 0));
    end
    checks++;
    if (iLog.size() !== nb || iLog[0].cyc !== ig + LAT || iLog[0].data !== readBeat(16'h0000, 0)) begin
      errors++;
      $display("[TB] FAIL sim_iread: got beats=%0d expected %0d first=%h", iLog.size(), nb, readBeat(16'h0000, 0));
    end
  endtask

  task automatic test_busy_reject();
    int g;
    dLog.delete(); iLog.delete();
    issue(1'b1, 1'b1, 16'h0030, 16'hC3C3, g);
    mdl[wordOf(16'h0030)] = 16'hC3C3;
    for (int k = 1; k <= 5; k++) begin
      bus.d_req = (k <= 3); bus.d_wr = 1'b1; bus.d_addr = 16'h0032; bus.d_wdata = 16'h7777;
      @(negedge clk);
      checks++;
      if (bus.d_gnt !== 1'b0 || bus.busy !== (k <= 4)) begin
        errors++;
        $display("[TB] FAIL busy_c%0d: got d_gnt=%b busy=%b expected d_gnt=0 busy=%0d", k, bus.d_gnt, bus.busy, k <= 4);
      end
      @(posedge clk);
      #1;
    end
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    checks++;
    if (dLog.size() !== 1 || dLog[0].cyc !== g + LAT || dLog[0].data !== 16'hC3C3) begin
      errors++;
      $display("[TB] FAIL busy_single: got %0d d beats expected 1 beat C3C3", dLog.size());
    end
  endtask

  task automatic test_wrap();
    int g, nb, k;
    nb = beatsFor(1'b0);
    k  = (BURST != 0) ? 1 : 0;
    issue(1'b1, 1'b1, 16'h0802, 16'hA5A5, g);
    mdl[wordOf(16'h0802)] = 16'hA5A5;
    waitUntil(g + LAT + 1);
    dLog.delete(); iLog.delete();
    issue(1'b1, 1'b0, 16'h0002, 16'h0, g);
    waitUntil(g + LAT + nb);
    checks++;
    if (dLog.size() !== nb || dLog[k].data !== 16'hA5A5 || dLog[k].idx !== 2'(k)) begin
      errors++;
      $display("[TB] FAIL wrap: got beats=%0d data=%h expected %0d beats, beat %0d=A5A5",
               dLog.size(), (dLog.size() > k) ? dLog[k].data : 16'h0, nb, k);
    end
  endtask

  task automatic test_reset_mid_write();
    int g, nb;
    nb = beatsFor(1'b0);
    issue(1'b1, 1'b1, 16'h0020, 16'h5555, g);
    mdl[wordOf(16'h0020)] = 16'h5555;
    waitUntil(g + LAT + 1);
    issue(1'b1, 1'b1, 16'h0020, 16'h1234, g);
    waitUntil(g + 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.d_gnt, bus.i_gnt, bus.d_valid, bus.i_valid, bus.busy, bus.beat_idx, bus.d_rdata, bus.i_rdata} !== 39'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outs: got busy=%b d_rdata=%h i_rdata=%h d_valid=%b expected all 0",
               bus.busy, bus.d_rdata, bus.i_rdata, bus.d_valid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dLog.delete(); iLog.delete();
    waitUntil(g + LAT + 3);
    checks++;
    if (dLog.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_novalid: got %0d d beats expected 0", dLog.size());
    end
    issue(1'b1, 1'b0, 16'h0020, 16'h0, g);
    waitUntil(g + LAT + nb);
    checks++;
    if (dLog.size() !== nb || dLog[0].data !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL midreset_nocommit: got beats=%0d data=%h expected %0d beats first=5555",
               dLog.size(), (dLog.size() > 0) ? dLog[0].data : 16'h0, nb);
    end
  endtask

  task automatic test_burst();
    logic [15:0] expD [4];
    int g, nb;
    expD = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    nb = beatsFor(1'b0);
    for (int b = 0; b < 4; b++) begin
      issue(1'b1, 1'b1, 16'(16'h0040 + 2 * b), expD[b], g);
      mdl[wordOf(16'h0040 + 2 * b)] = expD[b];
      waitUntil(g + LAT + 1);
    end
    dLog.delete(); iLog.delete();
    issue(1'b1, 1'b0, 16'h0044, 16'h0, g);
    for (int c = g + 1; c <= g + LAT + nb; c++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== (c < g + LAT + nb)) begin
        errors++;
        $display("[TB] FAIL burst_busy_c%0d: got %b expected %0d", c - g, bus.busy, c < g + LAT + nb);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (dLog.size() !== nb) begin
      errors++;
      $display("[TB] FAIL burst_count: got %0d beats expected %0d", dLog.size(), nb);
    end
    for (int b = 0; b < nb && b < dLog.size(); b++) begin
      checks++;
      if (dLog[b].cyc !== g + LAT + b || dLog[b].idx !== 2'(b) ||
          dLog[b].data !== ((BURST != 0) ? expD[b] : 16'h3333)) begin
        errors++;
        $display("[TB] FAIL burst_beat%0d: got cyc=%0d idx=%0d data=%h expected cyc=%0d idx=%0d data=%h",
                 b, dLog[b].cyc - g, dLog[b].idx, dLog[b].data, LAT + b, b,
                 (BURST != 0) ? expD[b] : 16'h3333);
      end
    end
  endtask

  task automatic test_random();
    bit          isD, wr;
    logic [15:0] addr, wd, exp;
    int          g, start, nb;
    beat_t       got[$];
    int          other;
    for (int t = 0; t < 40; t++) begin
      isD  = 1'($urandom_range(0, 1));
      wr   = isD & 1'($urandom_range(0, 1));
      addr = 16'(($urandom & 32'h0000_F800) | ($urandom_range(0, 63) << 1) | ($urandom & 32'h1));
      wd   = 16'($urandom);
      nb   = beatsFor(wr);
      dLog.delete(); iLog.delete();
      start = cyc;
      issue(isD, wr, addr, wd, g);
      waitUntil(g + LAT + nb);
      if (isD) begin got = dLog; other = iLog.size(); end
      else     begin got = iLog; other = dLog.size(); end
      checks++;
      if (g !== start || got.size() !== nb || other !== 0) begin
        errors++;
        $display("[TB] FAIL rand%0d_shape: got gnt=%0d beats=%0d other=%0d expected gnt=%0d beats=%0d other=0",
                 t, g, got.size(), other, start, nb);
      end
      for (int b = 0; b < nb && b < got.size(); b++) begin
        exp = wr ? wd : readBeat(addr, b);
        checks++;
        if (got[b].cyc !== g + LAT + b || got[b].data !== exp || got[b].idx !== 2'(b)) begin
          errors++;
          $display("[TB] FAIL rand%0d_beat%0d: addr=%h wr=%0d got cyc=%0d data=%h idx=%0d expected cyc=%0d data=%h idx=%0d",
                   t, b, addr, wr, got[b].cyc - g, got[b].data, got[b].idx, LAT + b, exp, b);
        end
      end
      if (wr) mdl[wordOf(addr)] = wd;
    end
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = 16'h0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
    test_reset();
    test_prefill();
    test_write_fetch();
    test_simultaneous();
    test_busy_reject();
    test_wrap();
    test_reset_mid_write();
    test_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
